// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the iterative floating-point multiplier.
package fp_mul_pkg;

  // Controller states, in the order an operation walks through them.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Rounding modes as encoded on rmode_i.
  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rmode_e;

  // Exponent bias for a given exponent field width.
  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Full word width: sign + exponent + stored mantissa.
  function automatic int word_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Width of the shift-add step counter (counts 0 .. man_w).
  function automatic int cnt_width(input int man_w);
    return $clog2(man_w + 1);
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational rounding plus overflow / underflow resolution for a
// normalised significand with guard, round and sticky bits.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_sign,
  input  logic signed [EXP_W+1:0]  i_exp,
  input  logic [MAN_W-1:0]         i_man,
  input  logic                     i_guard,
  input  logic                     i_round,
  input  logic                     i_sticky,
  input  rmode_e                   i_rmode,
  output logic [EXP_W+MAN_W:0]     o_product,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic                     o_inexact
);

  localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

  logic                    w_inexact;
  logic                    w_round_up;
  logic                    w_to_inf;
  logic [MAN_W:0]          w_man_sum;
  logic signed [EXP_W+1:0] w_exp_adj;

  // Decide the increment, apply it, then clamp the exponent range.
  always_comb begin
    w_inexact  = i_guard | i_round | i_sticky;
    w_round_up = 1'b0;
    case (i_rmode)
      RM_RNE:  w_round_up = i_guard & (i_round | i_sticky | i_man[0]);
      RM_RUP:  w_round_up = ~i_sign & w_inexact;
      RM_RDN:  w_round_up = i_sign & w_inexact;
      default: w_round_up = 1'b0;
    endcase

    // A carry out of the mantissa leaves the stored field at zero and
    // bumps the exponent by one (1.111..1 + ulp = 10.000..0).
    w_man_sum = {1'b0, i_man} + {{MAN_W{1'b0}}, w_round_up};
    w_exp_adj = i_exp + $signed({{(EXP_W+1){1'b0}}, w_man_sum[MAN_W]});

    // Overflow saturates to infinity only when rounding moves away from zero.
    w_to_inf = (i_rmode == RM_RNE) |
               ((i_rmode == RM_RUP) & ~i_sign) |
               ((i_rmode == RM_RDN) &  i_sign);

    o_product   = {i_sign, w_exp_adj[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = w_inexact;

    if (w_exp_adj >= EXP_MAX) begin
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
      o_product  = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (w_exp_adj < EXP_ONE) begin
      // No subnormal outputs: flush to signed zero.
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
      o_product   = {i_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_param.sv
// Iterative IEEE-style multiplier: radix-2 shift-add over the significands,
// one normalisation step, then rounding. Subnormal inputs are read as zero
// and subnormal results are flushed to zero.
//
// Handshake: start_i is accepted only while busy_o is low (IDLE); the
// operands and mode are captured on that edge and the flags are cleared.
// done_o pulses for one cycle when product_o and the flags are valid; they
// then hold until the next accepted start. There is no back-pressure.
module fp_mul_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic [1:0]             rmode_i,
  output logic [EXP_W+MAN_W:0]   product_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   nan_o,
  output logic                   infinit_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   inexact_o,
  output logic [2:0]             state_o
);

  localparam int W   = word_width(EXP_W, MAN_W);
  localparam int N   = MAN_W + 1;
  localparam int EW2 = EXP_W + 2;
  localparam int CW  = cnt_width(MAN_W);
  localparam logic [CW-1:0]         CNT_LAST = CW'(MAN_W);
  localparam logic signed [EW2-1:0] BIAS     = EW2'(exp_bias(EXP_W));

  state_e                r_state, w_state_nxt;
  logic [W-1:0]          r_a, r_b;
  rmode_e                r_rmode;
  logic                  r_sign;
  logic [2*N-1:0]        r_acc;
  logic [N-1:0]          r_mcand;
  logic [CW-1:0]         r_cnt;
  logic signed [EW2-1:0] r_exp;
  logic [2*N-1:0]        r_norm;
  logic [W-1:0]          r_res_product;
  logic                  r_res_ovf, r_res_unf, r_res_inx;
  logic [W-1:0]          r_product;
  logic                  r_nan, r_inf, r_ovf, r_unf, r_inx, r_done;

  // Operand decode from the captured words.
  logic [EXP_W-1:0]      w_exp_a, w_exp_b;
  logic [MAN_W-1:0]      w_man_a, w_man_b;
  logic                  w_sign;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                  w_any_nan, w_any_inf, w_special;
  logic [W-1:0]          w_spec_product;
  logic signed [EW2-1:0] w_exp_sum;
  logic [N:0]            w_hi_sum;

  logic [W-1:0]          w_rnd_product;
  logic                  w_rnd_ovf, w_rnd_unf, w_rnd_inx;

  assign w_exp_a  = r_a[W-2 -: EXP_W];
  assign w_exp_b  = r_b[W-2 -: EXP_W];
  assign w_man_a  = r_a[MAN_W-1:0];
  assign w_man_b  = r_b[MAN_W-1:0];
  assign w_sign   = r_a[W-1] ^ r_b[W-1];

  // Exponent field zero covers both true zero and subnormals.
  assign w_a_zero = (w_exp_a == '0);
  assign w_b_zero = (w_exp_b == '0);
  assign w_a_inf  = (w_exp_a == '1) && (w_man_a == '0);
  assign w_b_inf  = (w_exp_b == '1) && (w_man_b == '0);
  assign w_a_nan  = (w_exp_a == '1) && (w_man_a != '0);
  assign w_b_nan  = (w_exp_b == '1) && (w_man_b != '0);

  assign w_any_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_any_inf = w_a_inf | w_b_inf;
  assign w_special = w_any_nan | w_any_inf | w_a_zero | w_b_zero;

  // Unbiased sum of exponents, kept signed with two spare bits.
  assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set; the caller shifts right.
  assign w_hi_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Result for NaN / infinity / zero operands, bypassing the datapath.
  always_comb begin
    w_spec_product = {w_sign, {(W-1){1'b0}}};
    if (w_any_nan) begin
      w_spec_product = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (w_any_inf) begin
      w_spec_product = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_sign      (r_sign),
    .i_exp       (r_exp),
    .i_man       (r_norm[2*N-2 -: MAN_W]),
    .i_guard     (r_norm[MAN_W]),
    .i_round     (r_norm[MAN_W-1]),
    .i_sticky    (|r_norm[MAN_W-2:0]),
    .i_rmode     (r_rmode),
    .o_product   (w_rnd_product),
    .o_overflow  (w_rnd_ovf),
    .o_underflow (w_rnd_unf),
    .o_inexact   (w_rnd_inx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = w_special ? S_DONE : S_MULT;
      S_MULT:   if (r_cnt == CNT_LAST) w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = S_ROUND;
      S_ROUND:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers, advanced by the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_rmode       <= RM_RNE;
      r_sign        <= 1'b0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_cnt         <= '0;
      r_exp         <= '0;
      r_norm        <= '0;
      r_res_product <= '0;
      r_res_ovf     <= 1'b0;
      r_res_unf     <= 1'b0;
      r_res_inx     <= 1'b0;
      r_product     <= '0;
      r_nan         <= 1'b0;
      r_inf         <= 1'b0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_inx         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_rmode <= rmode_e'(rmode_i);
            r_nan   <= 1'b0;
            r_inf   <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_inx   <= 1'b0;
          end
        end
        S_UNPACK: begin
          r_sign  <= w_sign;
          r_exp   <= w_exp_sum;
          r_mcand <= {1'b1, w_man_a};
          r_acc   <= {{N{1'b0}}, 1'b1, w_man_b};
          r_cnt   <= '0;
        end
        S_MULT: begin
          r_acc <= {w_hi_sum, r_acc[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_NORM: begin
          // Product of two [1,2) significands is in [1,4): align the leading
          // one to the top bit, bumping the exponent for the [2,4) case.
          if (r_acc[2*N-1]) begin
            r_norm <= r_acc;
            r_exp  <= r_exp + EW2'(1);
          end else begin
            r_norm <= {r_acc[2*N-2:0], 1'b0};
          end
        end
        S_ROUND: begin
          r_res_product <= w_rnd_product;
          r_res_ovf     <= w_rnd_ovf;
          r_res_unf     <= w_rnd_unf;
          r_res_inx     <= w_rnd_inx;
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (w_special) begin
            r_product <= w_spec_product;
            r_nan     <= w_any_nan;
            r_inf     <= w_any_inf;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inx     <= 1'b0;
          end else begin
            r_product <= r_res_product;
            r_nan     <= 1'b0;
            r_inf     <= 1'b0;
            r_ovf     <= r_res_ovf;
            r_unf     <= r_res_unf;
            r_inx     <= r_res_inx;
          end
        end
        default: ;
      endcase
    end
  end

  assign product_o   = r_product;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign nan_o       = r_nan;
  assign infinit_o   = r_inf;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;
  assign inexact_o   = r_inx;
  assign state_o     = r_state;

endmodule

// File: tb/tb_fp_mul_param.sv
// Bench for fp_mul_param at default parameters (binary32 layout).
module tb_fp_mul_param;
  import fp_mul_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic [1:0]   rmode_i;
  logic [W-1:0] product_o;
  logic         busy_o, done_o;
  logic         nan_o, infinit_o, overflow_o, underflow_o, inexact_o;
  logic [2:0]   state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+4:0] exp_q[$];

  fp_mul_param dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .rmode_i     (rmode_i),
    .product_o   (product_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .nan_o       (nan_o),
    .infinit_o   (infinit_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .inexact_o   (inexact_o),
    .state_o     (state_o)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {nan_o, infinit_o, overflow_o, underflow_o, inexact_o};
  endfunction

  // Reference: exact integer product of the significands, then rounding
  // decided by comparing the discarded remainder against one half ulp.
  // Flags are {nan, inf, overflow, underflow, inexact}.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] rm, output logic [31:0] prod,
                                  output logic [4:0] flg, output bit special);
    int ea, eb, e, msb, sh;
    logic [63:0] p, kept, rem, half;
    bit s, za, zb, ia, ib, na, nb, inx, up, to_inf;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    flg = '0;
    prod = '0;
    special = 1'b1;
    if (na || nb || (ia && zb) || (ib && za)) begin
      prod = 32'h7FC00000;
      flg  = {1'b1, ia || ib, 3'b000};
      return;
    end
    if (ia || ib) begin
      prod = {s, 8'hFF, 23'h0};
      flg  = 5'b01000;
      return;
    end
    if (za || zb) begin
      prod = {s, 31'h0};
      return;
    end
    special = 1'b0;
    p = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
    msb = 0;
    for (int i = 63; i >= 0; i--) begin
      if (p[i]) begin
        msb = i;
        break;
      end
    end
    sh   = msb - 23;
    kept = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    e    = ea + eb - 127 + (msb - 46);
    inx  = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && kept[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && inx;
      default: up = s && inx;
    endcase
    kept = kept + 64'(up);
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'd0) || ((rm == 2'd2) && !s) || ((rm == 2'd3) && s);
      prod   = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      flg    = 5'b00101;
    end else if (e < 1) begin
      prod = {s, 31'h0};
      flg  = 5'b00011;
    end else begin
      prod = {s, 8'(e), kept[22:0]};
      flg  = {4'b0000, inx};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      v[30:23] = 8'hFF;
    else if (k == 1) begin v[30:23] = 8'hFF; v[22:0] = '0; end
    else if (k == 2) v[30:23] = 8'h00;
    else if (k < 11) v[30:23] = 8'($urandom_range(96, 158));
    else             v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // Drive one operation and score it. With noisy set, start_i stays high
  // with changing operands for the whole operation, including DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input bit noisy);
    logic [31:0]  ep;
    logic [4:0]   ef;
    logic [W+4:0] item;
    bit sp;
    int lat;
    ref_mul(a, b, rm, ep, ef, sp);
    exp_q.push_back({ef, ep});
    @(negedge clk);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    rmode_i = rm;
    @(posedge clk);
    #1;
    if (!noisy) start_i = 1'b0;
    lat = 0;
    while (lat < 100) begin
      if (noisy) begin
        a_i     = $urandom;
        b_i     = $urandom;
        rmode_i = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      lat++;
      if (done_o) break;
    end
    start_i = 1'b0;
    item = exp_q.pop_front();
    check("latency", 64'(lat), sp ? 64'd2 : 64'd28);
    check("product", 64'(product_o), 64'(item[31:0]));
    check("flags", 64'(flags_now()), 64'(item[36:32]));
    check("busy_at_done", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done_o), 64'd0);
    check("product_hold", 64'(product_o), 64'(item[31:0]));
    check("flags_hold", 64'(flags_now()), 64'(item[36:32]));
  endtask

  initial begin
    int dones;
    logic [31:0] ra, rb;

    rst     = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    rmode_i = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_product", 64'(product_o), 64'd0);
    check("rst_flags", 64'(flags_now()), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(32'h40400000, 32'h40000000, 2'd0, 1'b0);
    run_op(32'h7FC00000, 32'h3F800000, 2'd0, 1'b0);
    run_op(32'h7F800000, 32'h00000000, 2'd0, 1'b0);
    run_op(32'hFF800000, 32'h40000000, 2'd0, 1'b0);
    run_op(32'h80000000, 32'h40400000, 2'd0, 1'b0);
    run_op(32'h7F000000, 32'h7F000000, 2'd0, 1'b0);
    run_op(32'h7F000000, 32'h7F000000, 2'd1, 1'b0);
    run_op(32'h00800000, 32'h3F000000, 2'd0, 1'b0);
    run_op(32'h3F800001, 32'h3F800001, 2'd0, 1'b0);
    run_op(32'h3F800001, 32'h3F800001, 2'd2, 1'b0);
    run_op(32'h3F7FFFFF, 32'h3F7FFFFF, 2'd3, 1'b0);
    run_op(32'hFF000000, 32'h7F000000, 2'd2, 1'b0);
    run_op(32'hFF000000, 32'h7F000000, 2'd3, 1'b0);

    // Reset ten cycles into MULT aborts the operation.
    @(negedge clk);
    start_i = 1'b1;
    a_i     = 32'h40400000;
    b_i     = 32'h40000000;
    rmode_i = 2'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_product", 64'(product_o), 64'd0);
    check("abort_flags", 64'(flags_now()), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_state", 64'(state_o), 64'(S_IDLE));
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Fresh operation after the abort, then one with start held during busy.
    run_op(32'h40400000, 32'h40000000, 2'd0, 1'b0);
    run_op(32'h3FC00000, 32'h40400000, 2'd0, 1'b1);
    run_op(32'h7F800000, 32'h3F800000, 2'd1, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, 2'($urandom_range(0, 3)), (i % 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
